storage_arbiter: RTL and testbench

- Parametrised N-port arbiter for the shared matrix storage RAM.
- Replaces the static enable-priority storage multiplexer.
- Requesters (input, display, calculator, future engines) raise requests concurrently.
- The arbiter grants one access per cycle in round-robin order, drives the RAM port and returns read data tagged to the issuing requester after the RAM read latency.
- Optional grant locking keeps burst accesses (e.g. matrix multiply operand streams) uninterrupted.

---
 rtl/storage_arbiter_if.sv | 30 +++
 rtl/storage_arbiter.sv | 131 +++++++++++++
 tb/tb_storage_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/storage_arbiter_if.sv
// Requester/RAM bundle for storage_arbiter. The slave modport is the arbiter
// side; master is the requesters and RAM side.
interface storage_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ-1:0]        i_we;
  logic [N_REQ-1:0]        i_lock;
  logic [N_REQ*ADDR_W-1:0] i_addr;
  logic [N_REQ*DATA_W-1:0] i_wdata;
  logic [N_REQ-1:0]        o_gnt;
  logic [N_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]       o_rdata;
  logic                    o_mem_we;
  logic [ADDR_W-1:0]       o_mem_addr;
  logic [DATA_W-1:0]       o_mem_wdata;
  logic [DATA_W-1:0]       i_mem_rdata;

  modport master (
    output i_req, i_we, i_lock, i_addr, i_wdata, i_mem_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport slave (
    input  i_req, i_we, i_lock, i_addr, i_wdata, i_mem_rdata,
    output o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/storage_arbiter.sv
// Round-robin N-port arbiter for the shared matrix storage RAM with tagged read return.
// Define STORAGE_ARB_LOCK_EN to enable grant locking for burst owners.
module storage_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  storage_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef logic [IDX_W-1:0] idx_t;

  idx_t              ptr_q;
  idx_t              win;
  logic              any;
  logic              lock_hit;
  logic [IDX_W:0]    sum;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  push;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [N_REQ-1:0]  tag_q [RD_LAT];

`ifdef STORAGE_ARB_LOCK_EN
  idx_t own_q;
  logic own_vld_q;

  // Ownership is re-established each cycle the owner wins with i_lock held,
  // so dropping either i_req or i_lock releases it at the end of that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_vld_q <= 1'b0;
      own_q     <= '0;
    end else if (any && bus.i_lock[win]) begin
      own_vld_q <= 1'b1;
      own_q     <= win;
    end else begin
      own_vld_q <= 1'b0;
    end
  end

  assign lock_hit = own_vld_q && bus.i_req[own_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.i_lock;
  assign lock_hit    = 1'b0;
`endif

  // Scan ptr, ptr+1, ... with wrap at N_REQ-1; the lock owner overrides.
  always_comb begin
    any = 1'b0;
    win = '0;
    sum = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      if (!any && bus.i_req[sum[IDX_W-1:0]]) begin
        any = 1'b1;
        win = sum[IDX_W-1:0];
      end
    end
`ifdef STORAGE_ARB_LOCK_EN
    if (lock_hit) begin
      any = 1'b1;
      win = own_q;
    end
`endif
    if (!rst_n) begin
      any = 1'b0;
    end
  end

  always_comb begin
    gnt       = '0;
    push      = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (any) begin
      gnt[win] = 1'b1;
      mem_we   = bus.i_we[win];
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (win == idx_t'(k)) begin
          mem_addr  = bus.i_addr[k*ADDR_W +: ADDR_W];
          mem_wdata = bus.i_wdata[k*DATA_W +: DATA_W];
        end
      end
      if (!mem_we) begin
        push = gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (any) begin
      ptr_q <= (win == idx_t'(N_REQ-1)) ? '0 : win + idx_t'(1);
    end
  end

  // Read tags travel alongside the RAM read latency; writes and idles push zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= push;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_rvalid    = tag_q[RD_LAT-1];
  assign bus.o_rdata     = bus.i_mem_rdata;

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter: three instances with RD_LAT 1, 2 and 3.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_storage_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  storage_arbiter_if #(.N_REQ(4), .ADDR_W(9), .DATA_W(32)) b1 ();
  storage_arbiter_if #(.N_REQ(4), .ADDR_W(9), .DATA_W(32)) b2 ();
  storage_arbiter_if #(.N_REQ(4), .ADDR_W(9), .DATA_W(32)) b3 ();

  storage_arbiter #(.N_REQ(4), .ADDR_W(9), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  storage_arbiter #(.N_REQ(4), .ADDR_W(9), .DATA_W(32), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));
  storage_arbiter #(.N_REQ(4), .ADDR_W(9), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave));

  // Single-cycle-latency RAM behind dut1.
  logic [31:0] mem1 [512];
  logic [31:0] rd1_q;
  always @(posedge clk) begin
    if (b1.o_mem_we) mem1[b1.o_mem_addr] <= b1.o_mem_wdata;
    rd1_q <= mem1[b1.o_mem_addr];
  end
  assign b1.i_mem_rdata = rd1_q;
  assign b2.i_mem_rdata = '0;
  assign b3.i_mem_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [3:0] exp_lock [7];
  logic [3:0] rv_exp;

  initial begin
`ifdef STORAGE_ARB_LOCK_EN
    exp_lock = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001};
`else
    exp_lock = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0100};
`endif
    b1.i_req = '0; b1.i_we = '0; b1.i_lock = '0; b1.i_addr = '0; b1.i_wdata = '0;
    b2.i_req = '0; b2.i_we = '0; b2.i_lock = '0; b2.i_addr = '0; b2.i_wdata = '0;
    b3.i_req = '0; b3.i_we = '0; b3.i_lock = '0; b3.i_addr = '0; b3.i_wdata = '0;

    // Reset holds grant and write enable low even with requests pending
    b1.i_req = 4'hF; b1.i_we = 4'hF;
    @(negedge clk); #1;
    chk("rst_gnt", b1.o_gnt, 4'b0000);
    chk("rst_mem_we", b1.o_mem_we, 1'b0);
    chk("rst_rvalid", b1.o_rvalid, 4'b0000);
    chk("rst_rvalid3", b3.o_rvalid, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1; b1.i_req = '0; b1.i_we = '0;

    // Port 2 stores 0xDEADBEEF at 0x05, then reads it back
    @(negedge clk);
    b1.i_req = 4'b0100; b1.i_we = 4'b0100;
    b1.i_addr[2*9 +: 9] = 9'h005; b1.i_wdata[2*32 +: 32] = 32'hDEADBEEF;
    #1;
    chk("wr5_gnt", b1.o_gnt, 4'b0100);
    chk("wr5_mem_we", b1.o_mem_we, 1'b1);
    @(negedge clk);
    b1.i_we = 4'b0000;
    #1;
    chk("rd5_gnt", b1.o_gnt, 4'b0100);
    chk("rd5_addr", b1.o_mem_addr, 9'h005);
    chk("rd5_mem_we", b1.o_mem_we, 1'b0);
    chk("rd5_no_rvalid_for_write", b1.o_rvalid, 4'b0000);
    @(negedge clk);
    b1.i_req = '0;
    #1;
    chk("rd5_rvalid", b1.o_rvalid, 4'b0100);
    chk("rd5_rdata", b1.o_rdata, 32'hDEADBEEF);
    chk("idle_gnt", b1.o_gnt, 4'b0000);
    chk("idle_addr", b1.o_mem_addr, 9'h000);
    @(negedge clk); #1;
    chk("rd5_rvalid_clear", b1.o_rvalid, 4'b0000);

    // All four ports request continuously from reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    b1.i_req = 4'hF; b1.i_we = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("rr_gnt", b1.o_gnt, 4'b0001 << (i % 4));
      rv_exp = (i == 0) ? 4'b0000 : 4'b0001 << ((i - 1) % 4);
      chk("rr_rvalid", b1.o_rvalid, rv_exp);
    end

    // Same-cycle write (port 0) and read (port 1) of address 7
    @(negedge clk);
    b1.i_req = 4'b0011; b1.i_we = 4'b0001;
    b1.i_addr[0 +: 9] = 9'h007; b1.i_addr[9 +: 9] = 9'h007;
    b1.i_wdata[0 +: 32] = 32'h12;
    #1;
    chk("wr7_gnt", b1.o_gnt, 4'b0001);
    chk("wr7_mem_we", b1.o_mem_we, 1'b1);
    chk("wr7_addr", b1.o_mem_addr, 9'h007);
    chk("wr7_wdata", b1.o_mem_wdata, 32'h12);
    @(negedge clk);
    b1.i_req = 4'b0010; b1.i_we = 4'b0000;
    #1;
    chk("rd7_gnt", b1.o_gnt, 4'b0010);
    chk("rd7_mem_we", b1.o_mem_we, 1'b0);
    chk("rd7_addr", b1.o_mem_addr, 9'h007);
    chk("rd7_no_rvalid", b1.o_rvalid, 4'b0000);
    @(negedge clk);
    b1.i_req = '0;
    #1;
    chk("rd7_rvalid", b1.o_rvalid, 4'b0010);
    chk("rd7_rdata", b1.o_rdata, 32'h12);

    // Move the pointer to port 1, then port 1 bursts with lock for 5 cycles
    @(negedge clk);
    b1.i_req = 4'b0001;
    #1;
    chk("pre_lock_gnt", b1.o_gnt, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      b1.i_req  = (i < 5) ? 4'b0111 : 4'b0101;
      b1.i_lock = (i < 5) ? 4'b0010 : 4'b0000;
      #1;
      chk("lock_gnt", b1.o_gnt, exp_lock[i]);
    end
    @(negedge clk);
    b1.i_req = '0; b1.i_lock = '0;

    // RD_LAT=3: reads on ports 1, 3, 0 in consecutive cycles
    b3.i_req = 4'b0010;
    #1;
    chk("lat3_gnt1", b3.o_gnt, 4'b0010);
    @(negedge clk);
    b3.i_req = 4'b1000;
    #1;
    chk("lat3_gnt3", b3.o_gnt, 4'b1000);
    chk("lat3_rv_c1", b3.o_rvalid, 4'b0000);
    @(negedge clk);
    b3.i_req = 4'b0001;
    #1;
    chk("lat3_gnt0", b3.o_gnt, 4'b0001);
    chk("lat3_rv_c2", b3.o_rvalid, 4'b0000);
    @(negedge clk);
    b3.i_req = '0;
    #1;
    chk("lat3_rv_c3", b3.o_rvalid, 4'b0010);
    @(negedge clk); #1;
    chk("lat3_rv_c4", b3.o_rvalid, 4'b1000);
    @(negedge clk); #1;
    chk("lat3_rv_c5", b3.o_rvalid, 4'b0001);
    @(negedge clk); #1;
    chk("lat3_rv_c6", b3.o_rvalid, 4'b0000);

    // RD_LAT=2: reset one cycle after a read grant discards the read
    @(negedge clk);
    b2.i_req = 4'b0100;
    #1;
    chk("lat2_gnt", b2.o_gnt, 4'b0100);
    @(negedge clk);
    b2.i_req = '0; rst_n = 1'b0;
    #1;
    chk("lat2_rv_in_rst", b2.o_rvalid, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("lat2_rv_dropped", b2.o_rvalid, 4'b0000);
    @(negedge clk);
    b2.i_req = 4'b1111;
    #1;
    chk("lat2_post_rst_gnt", b2.o_gnt, 4'b0001);
    chk("lat2_post_rst_rv", b2.o_rvalid, 4'b0000);
    @(negedge clk);
    b2.i_req = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
